seq_shift_tx: RTL
=================

Name: seq_shift_tx

Overview:
- Parallel-to-serial transmitter: the sending end of a byte-load register interface.
- Accepts a WIDTH-bit word on an enable handshake and shifts it out one bit per clock with valid/last framing.
- Feeds a downstream serial-to-parallel capture register.
- Serves as a sequential benchmark with an FSM, counter, shift register and gapless back-to-back reload.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low: sampled only at posedge clk, state cleared when rst == 0.
- en  input  1  load request; word accepted at posedge when en && ready.
- d  input  WIDTH  parallel word, sampled only on an accepted load.
- ready  output  1  transmitter can accept a load this cycle.
- sdo  output  1  serial data bit.
- sdo_valid  output  1  sdo carries a frame bit this cycle.
- last  output  1  current sdo bit is the final bit of the frame.

Behaviour:
- State: state_t {IDLE, SHIFT}, shift register shreg[WIDTH-1:0], bit counter cnt[$clog2(WIDTH)-1:0].
- Reset at posedge with rst == 0, which has priority over everything:
  - state=IDLE, shreg=0, cnt=0.
  - Outputs: ready=1, sdo=0, sdo_valid=0, last=0.
- Outputs are decoded from registered state only, with no combinational path from en or d:
  - sdo_valid = (state==SHIFT).
  - last = (state==SHIFT) && (cnt==WIDTH-1).
  - ready = (state==IDLE) || last.
  - sdo = LSB_FIRST ? shreg[0] : shreg[WIDTH-1].
  - sdo is forced to 0 in IDLE.
- IDLE:
  - en==1: shreg<=d, cnt<=0, state<=SHIFT.
  - en==0: hold.
- SHIFT, not last:
  - Shift shreg by one toward the output end (logical shift, zero fill) and increment cnt.
  - en is ignored; d is not captured and the frame is not disturbed.
- SHIFT, last:
  - en==1: shreg<=d, cnt<=0, stay in SHIFT. This gives a gapless next frame: the new bit 0 appears the very next cycle.
  - en==0: state<=IDLE, cnt<=0.
- Latency: first frame bit appears on sdo the cycle after acceptance. Exactly WIDTH consecutive sdo_valid cycles per frame.
- Counter wrap: cnt never exceeds WIDTH-1. It resets to 0 on every load or exit, so no modulo arithmetic is needed for non-power-of-2 WIDTH.
- Reset mid-frame: the frame is aborted immediately. The next cycle shows ready=1 and sdo_valid=0, and no partial bits resume.
- rst==0 together with en==1: reset wins and the load is dropped.

Decomposition:
- Package seq_shift_pkg holds typedef enum logic {IDLE, SHIFT} state_t.
- WIDTH-derived widths (CNT_W = $clog2(WIDTH)) are localparams inside the module.
- No sub-module: the counter and shift register are small enough to stay inline in a single always_ff with a separate always_comb output decode.

Test Plan:
- Reset: hold rst=0 for 2 cycles with en=1, d=8'hFF -> ready=1, sdo_valid=0, sdo=0, last=0 throughout; no frame starts after release until en is raised again.
- Single frame (WIDTH=8, LSB_FIRST=1): en=1, d=8'hA5 for one cycle ->
  - sdo sequence 1,0,1,0,0,1,0,1 over 8 cycles with sdo_valid=1;
  - last=1 only on the 8th bit;
  - then ready=1, sdo_valid=0.
- MSB-first (LSB_FIRST=0): d=8'h81 -> sdo 1,0,0,0,0,0,0,1.
- Busy ignore: load 8'h0F, then en=1, d=8'hF0 on cycles 2-6 of the frame -> the serial stream remains 1,1,1,1,0,0,0,0 and ready=0 on those cycles.
- Back-to-back: en=1 held with d=8'h01 then 8'h80 presented at last -> 16 consecutive sdo_valid cycles with no gap; last pulses on cycles 8 and 16.
- Mid-frame reset: load 8'hFF, assert rst=0 on the 4th bit -> the next cycle shows sdo_valid=0, ready=1; after release with en=0 the block stays idle.

Source files
------------

// File: rtl/seq_shift_pkg.sv
// Shared types for the seq_shift parallel-to-serial transmitter.
package seq_shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_shift_tx.sv
// Parallel-to-serial transmitter: loads a WIDTH-bit word on en && ready and shifts it out
// one bit per clock with valid/last framing; reloading on the last bit gives gapless frames.
module seq_shift_tx
  import seq_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             last
);

  localparam int unsigned     CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               at_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          shreg_d = d;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (at_last) begin
          // Reload on the final bit keeps the stream gapless.
          cnt_d = '0;
          if (en) begin
            shreg_d = d;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registered state only; en and d never reach them combinationally.
  always_comb begin
    at_last   = (state_q == SHIFT) && (cnt_q == CntLast);
    sdo_valid = (state_q == SHIFT);
    last      = at_last;
    ready     = (state_q == IDLE) || at_last;
    sdo       = 1'b0;
    if (state_q == SHIFT) begin
      sdo = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    end
  end

endmodule
